// File: rtl/daqrdcap.sv
// daqrdcap: ADC parallel-read capture engine.
// On each end of conversion it enables the read-clock generator. It latches one
// ADC word per read-clock falling edge until NCH words are collected. Words are
// queued in a small show-ahead FIFO and leave on a valid/ready stream.
// Optional build macro DAQRDCAP_CHTAG_EN adds a 4-bit channel tag (chan_o)
// stored alongside each word.
module daqrdcap #(
    parameter int NCH     = 8,
    parameter int DW      = 16,
    parameter int FIFO_AW = 3
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          en_i,
    input  logic          busy_i,
    input  logic          rdclk_i,
    output logic          rden_o,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] dat_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          ovf_o,
    output logic          miss_o,
    input  logic          clr_i,
`ifdef DAQRDCAP_CHTAG_EN
    output logic [3:0]    chan_o,
`endif
    output logic          frame_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, CAP, DONE} state_t;

    state_t               state;
    logic                 busy_s1, busy_s2, busy_s3, eoc;
    logic                 rdclk_q, rdclk_d, fall;
    logic [3:0]           chcnt;
    logic                 wr_pend;
    logic [DW-1:0]        cap_word;
    logic [DW-1:0]        mem [DEPTH];
    logic [FIFO_AW:0]     wptr, rptr, rptr_n;
    logic                 full, rd, wr_ok, drop, miss_set;
`ifdef DAQRDCAP_CHTAG_EN
    logic [3:0]           cap_tag;
    logic [3:0]           tag_mem [DEPTH];
`endif

    // BUSY synchronizer, idle-high; eoc is a registered falling-edge pulse
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_s1 <= 1'b1;
            busy_s2 <= 1'b1;
            busy_s3 <= 1'b1;
            eoc     <= 1'b0;
        end else begin
            busy_s1 <= busy_i;
            busy_s2 <= busy_s1;
            busy_s3 <= busy_s2;
            eoc     <= busy_s3 & ~busy_s2;
        end
    end

    // Read-clock level history for falling-edge detection
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdclk_q <= 1'b0;
            rdclk_d <= 1'b0;
        end else begin
            rdclk_q <= rdclk_i;
            rdclk_d <= rdclk_q;
        end
    end

    assign fall = rdclk_d & ~rdclk_q;

    // Frame FSM: enables the generator and counts captured channels
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            rden_o  <= 1'b0;
            chcnt   <= 4'd0;
            wr_pend <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            frame_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (eoc && en_i) begin
                        state  <= CAP;
                        rden_o <= 1'b1;
                        chcnt  <= 4'd0;
                    end
                end
                CAP: begin
                    if (fall) begin
                        wr_pend <= 1'b1;
                        if (chcnt == 4'(NCH - 1)) begin
                            state   <= DONE;
                            rden_o  <= 1'b0;
                            frame_o <= 1'b1;
                        end else begin
                            chcnt <= chcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    rden_o <= 1'b0;
                end
            endcase
        end
    end

    // Word (and tag) latch on each in-frame read-clock fall
    always_ff @(posedge clk_i) begin
        if (state == CAP && fall) begin
            cap_word <= data_i;
`ifdef DAQRDCAP_CHTAG_EN
            cap_tag  <= chcnt;
`endif
        end
    end

    assign full     = (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]) && (wptr[FIFO_AW] != rptr[FIFO_AW]);
    assign rd       = valid_o && ready_i;
    // A read in the same cycle frees the head slot, so a write at full still fits
    assign wr_ok    = wr_pend && (!full || rd);
    assign drop     = wr_pend && full && !rd;
    assign rptr_n   = rptr + {{FIFO_AW{1'b0}}, rd};
    assign miss_set = eoc && (state == CAP || state == DONE);

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wptr[FIFO_AW-1:0]]     <= cap_word;
`ifdef DAQRDCAP_CHTAG_EN
            tag_mem[wptr[FIFO_AW-1:0]] <= cap_tag;
`endif
        end
    end

    // FIFO pointers and registered show-ahead head; rptr addresses the word on dat_o
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr    <= '0;
            rptr    <= '0;
            valid_o <= 1'b0;
            dat_o   <= '0;
`ifdef DAQRDCAP_CHTAG_EN
            chan_o  <= 4'd0;
`endif
        end else begin
            wptr    <= wptr + {{FIFO_AW{1'b0}}, wr_ok};
            rptr    <= rptr_n;
            valid_o <= (wptr != rptr_n);
            dat_o   <= mem[rptr_n[FIFO_AW-1:0]];
`ifdef DAQRDCAP_CHTAG_EN
            chan_o  <= tag_mem[rptr_n[FIFO_AW-1:0]];
`endif
        end
    end

    // Sticky error flags; a same-cycle set overrides clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ovf_o  <= 1'b0;
            miss_o <= 1'b0;
        end else begin
            ovf_o  <= drop     ? 1'b1 : (clr_i ? 1'b0 : ovf_o);
            miss_o <= miss_set ? 1'b1 : (clr_i ? 1'b0 : miss_o);
        end
    end

endmodule

// File: doc/daqrdcap.md
# daqrdcap

Capture engine for the ADC parallel read path, the receiving end of the DAQ read-clock generator. On each end of conversion it enables the read-clock generator, latches one ADC word on every falling edge of the read clock until `NCH` channels are collected, then releases the generator. Captured words go through a small FIFO and leave on a valid/ready stream toward the USB/host packetiser.

## Interface
- `NCH`, 8: channels per conversion frame (1..15).
- `DW`, 16: ADC data bus width.
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW = 8.
- `clk_i` in 1: 200 MHz system clock; same clock that drives the read-clock generator.
- `reset_i` in 1: reset, asynchronous, active-high. Clock is `clk_i`.
- `en_i` in 1: arm capture; frames start only while high.
- `busy_i` in 1: ADC BUSY, asynchronous; high during conversion.
- `rdclk_i` in 1: read-clock level from the generator, synchronous to `clk_i`.
- `rden_o` out 1: drives the generator enable input.
- `data_i` in DW: ADC parallel data; stable around the `rdclk_i` falling edge.
- `dat_o` out DW: FIFO head word.
- `valid_o` out 1: `dat_o` valid.
- `ready_i` in 1: consumer accepts.
- `ovf_o` out 1: sticky; a word was dropped on FIFO full.
- `miss_o` out 1: sticky; a conversion ended while a frame was still in progress.
- `clr_i` in 1: synchronous clear of `ovf_o` and `miss_o`.
- `frame_o` out 1: one-cycle pulse when the last word of a frame is written.

## Operation
- `busy_i` passes through a 2-flop synchronizer, then a third flop for falling-edge detection (`eoc`).
- `rdclk_i` is registered once; `fall` = previous high and current low.
- FSM states:
  - IDLE: `rden_o`=0. Goes to CAP on `eoc && en_i`.
  - CAP: `rden_o`=1. On each `fall`, latch `data_i` and increment the 4-bit `chcnt`. When `chcnt` reaches NCH-1 on a `fall`, go to DONE.
  - DONE: `rden_o`=0 for one cycle, then go to IDLE.
- `chcnt` clears on entry to CAP.
- `fall` events outside CAP are ignored.
- `eoc` while in CAP or DONE sets `miss_o`. The current frame continues, and the new conversion is not captured.
- `en_i` dropping mid-frame does not abort the frame; it only blocks the next one.
- FIFO:
  - Write on the cycle after `fall`, using the latched word.
  - Read when `valid_o && ready_i`.
  - A simultaneous read and write at full is allowed: the write succeeds and `ovf_o` is not set.
  - Write at full otherwise drops the word and sets `ovf_o`. The FIFO contents are unchanged and `chcnt` still advances.
  - Pointers are FIFO_AW+1 bits with wrap bit. Full is when the pointers are equal except for the MSB; empty is when they are fully equal.
- `clr_i` and a same-cycle set: the set wins.

## Timing
- Reset values:
  - FSM=IDLE, `rden_o`=0, `valid_o`=0, `dat_o`=0, `ovf_o`=0, `miss_o`=0, `frame_o`=0.
  - FIFO empty, synchronizer flops 1 (BUSY idle-high safe).
- Start latency: `busy_i` falls at edge N, `eoc` is asserted at edge N+3, and `rden_o` rises at edge N+4.
- Capture: `rdclk_i` falls before edge M. `fall` is seen at M+1, the word is latched at M+1, and it is written to the FIFO at M+2.
- Output: `valid_o` rises at M+3 when the FIFO was empty. `dat_o` is registered show-ahead.
- `frame_o` pulses in the same cycle as the FIFO write of word NCH-1.
- `rden_o` falls on the edge after the NCH-th `fall`. Minimum frame length with generator defaults: NCH×9 cycles plus 5.
- Reset mid-frame returns to IDLE immediately with `rden_o`=0; the partial frame is discarded.

## Configuration
- `DAQRDCAP_CHTAG_EN` defined:
  - Adds output `chan_o` [3:0], stored in the FIFO alongside each word and holding the channel index of `dat_o`.
  - Word 0 of each frame always carries tag 0.
- Not defined: no `chan_o` port and no tag storage in the FIFO; channel order is implied by position in the stream.

## Test plan
- Reset, then `en_i`=1, `ready_i`=1; drop `busy_i` once; the ADC model drives 0x1000+ch on each `fall` -> 8 words 0x1000..0x1007 in order, one `frame_o` pulse, `rden_o` high for exactly the capture window, flags 0.
- `ready_i`=0, two frames (16 words) with FIFO depth 8 -> first 8 words retained, `ovf_o`=1; then `ready_i`=1 -> 0x1000..0x1007 drained, `valid_o`=0 after.
- Second `busy_i` fall at word 3 of a frame -> `miss_o`=1, that frame still completes with 8 words, and no ninth word appears.
- `en_i`=0 with `busy_i` toggling -> `rden_o` stays 0, no words, no flags; assert `clr_i` with `ovf_o`=1 -> cleared next edge.
- `reset_i` pulsed at word 5 -> `rden_o`=0 and `valid_o`=0 immediately; the next conversion yields a clean 8-word frame.
- With `DAQRDCAP_CHTAG_EN`: one frame -> `chan_o` reads 0..7 matching `dat_o`.
